// File: rtl/stdp_weight_update.sv
// ---------------------------------------------------------------------------
// stdp_weight_update
//
// Pair-based STDP learning stage for a single synapse. Two saturating trace
// counters record how many cycles ago the presynaptic and postsynaptic
// neurons last spiked. When one neuron spikes while its partner's trace is
// still inside the learning window, the weight is potentiated (post after
// pre) or depressed (pre after post). The step size halves every
// 2^TAU_LOG2 cycles of spike-time difference.
//
// Optional build macro: STDP_WEIGHT_DECAY_EN
//   When defined, an idle counter of DECAY_LOG2 bits drifts the weight by
//   one step toward W_INIT each time it wraps without an intervening spike.
//   This drift only happens while learn_en is high, and it does not pulse
//   update_flag.
//
// Ports:
//   clk          clock
//   rst_n        asynchronous active-low reset
//   pre_spike    presynaptic spike, one-cycle pulse
//   post_spike   postsynaptic spike, one-cycle pulse
//   learn_en     1 = weight updates allowed (trace counters always run)
//   weight       current synaptic weight, registered
//   update_flag  one-cycle pulse on an LTP/LTD event
//   ltp          direction of the last event (1 = potentiation)
//   time_diff    spike-time difference of the last event, registered
// ---------------------------------------------------------------------------
module stdp_weight_update #(
  parameter int WEIGHT_W   = 8,
  parameter int W_INIT     = 64,
  parameter int A_MAX      = 16,
  parameter int TAU_LOG2   = 2,
  parameter int WINDOW     = 16,
  parameter int CNT_W      = 5,
  parameter int DECAY_LOG2 = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pre_spike,
  input  logic                post_spike,
  input  logic                learn_en,
  output logic [WEIGHT_W-1:0] weight,
  output logic                update_flag,
  output logic                ltp,
  output logic [CNT_W-1:0]    time_diff
);

  localparam logic [CNT_W-1:0]    WIN_C   = CNT_W'(WINDOW);
  localparam logic [WEIGHT_W-1:0] INIT_C  = WEIGHT_W'(W_INIT);
  localparam logic [WEIGHT_W-1:0] AMAX_C  = WEIGHT_W'(A_MAX);
  localparam logic [WEIGHT_W-1:0] WMAX_C  = {WEIGHT_W{1'b1}};

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0]    pre_cnt_q,  pre_cnt_d;
  logic [CNT_W-1:0]    post_cnt_q, post_cnt_d;
  logic [WEIGHT_W-1:0] weight_q,   weight_d;
  logic                flag_q,     flag_d;
  logic                ltp_q,      ltp_d;
  logic [CNT_W-1:0]    tdiff_q,    tdiff_d;

  // -------------------------------------------------------------------------
  // Trace counters: restart at 0 on a spike, otherwise count up and stick at
  // WINDOW, which marks the trace as no longer usable for pairing.
  // -------------------------------------------------------------------------
  always_comb begin
    pre_cnt_d  = pre_cnt_q;
    post_cnt_d = post_cnt_q;
    if (pre_spike)
      pre_cnt_d = '0;
    else if (pre_cnt_q < WIN_C)
      pre_cnt_d = pre_cnt_q + CNT_W'(1);
    if (post_spike)
      post_cnt_d = '0;
    else if (post_cnt_q < WIN_C)
      post_cnt_d = post_cnt_q + CNT_W'(1);
  end

  // -------------------------------------------------------------------------
  // Event detection and magnitude
  // -------------------------------------------------------------------------
  logic                pre_valid, post_valid;
  logic                ltp_evt, ltd_evt;
  logic [CNT_W-1:0]    partner_cnt;
  logic [CNT_W-1:0]    dt;
  logic [WEIGHT_W-1:0] mag;
  logic [WEIGHT_W:0]   sum_w, diff_w;

  assign pre_valid  = (pre_cnt_q  < WIN_C);
  assign post_valid = (post_cnt_q < WIN_C);

  // Simultaneous spikes are excluded from both directions.
  assign ltp_evt = post_spike & ~pre_spike & pre_valid;
  assign ltd_evt = pre_spike & ~post_spike & post_valid;

  // The partner counter was cleared on the partner's spike edge, so it lags
  // the true spike-time difference by one: dt = cnt + 1, and the decay bin
  // index (dt-1) >> TAU_LOG2 is simply cnt >> TAU_LOG2.
  assign partner_cnt = post_spike ? pre_cnt_q : post_cnt_q;
  assign dt          = partner_cnt + CNT_W'(1);
  assign mag         = AMAX_C >> (partner_cnt >> TAU_LOG2);

  // One extra bit catches carry out of the sum and borrow out of the
  // difference so the weight clamps instead of wrapping.
  assign sum_w  = {1'b0, weight_q} + {1'b0, mag};
  assign diff_w = {1'b0, weight_q} - {1'b0, mag};

  // -------------------------------------------------------------------------
  // Optional idle-decay toward W_INIT
  // -------------------------------------------------------------------------
  logic decay_tick;

`ifdef STDP_WEIGHT_DECAY_EN
  logic [DECAY_LOG2-1:0] idle_q, idle_d;

  always_comb begin
    idle_d = idle_q + DECAY_LOG2'(1);
    if (pre_spike || post_spike)
      idle_d = '0;
  end

  // Wrap happens only on a spike-free cycle, so it never coincides with an
  // LTP/LTD event.
  assign decay_tick = ~(pre_spike | post_spike) & (&idle_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      idle_q <= '0;
    else
      idle_q <= idle_d;
  end
`else
  logic unused_cfg;

  assign decay_tick = 1'b0;
  // Keeps the decay period parameter referenced when the drift is compiled out.
  assign unused_cfg = (DECAY_LOG2 > 0);
`endif

  // -------------------------------------------------------------------------
  // Weight / event output next-state
  // -------------------------------------------------------------------------
  always_comb begin
    weight_d = weight_q;
    flag_d   = 1'b0;
    ltp_d    = ltp_q;
    tdiff_d  = tdiff_q;
    if (learn_en) begin
      if (ltp_evt) begin
        weight_d = sum_w[WEIGHT_W] ? WMAX_C : sum_w[WEIGHT_W-1:0];
        flag_d   = 1'b1;
        ltp_d    = 1'b1;
        tdiff_d  = dt;
      end else if (ltd_evt) begin
        weight_d = diff_w[WEIGHT_W] ? '0 : diff_w[WEIGHT_W-1:0];
        flag_d   = 1'b1;
        ltp_d    = 1'b0;
        tdiff_d  = dt;
      end else if (decay_tick) begin
        if (weight_q > INIT_C)
          weight_d = weight_q - WEIGHT_W'(1);
        else if (weight_q < INIT_C)
          weight_d = weight_q + WEIGHT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q  <= WIN_C;
      post_cnt_q <= WIN_C;
      weight_q   <= INIT_C;
      flag_q     <= 1'b0;
      ltp_q      <= 1'b0;
      tdiff_q    <= '0;
    end else begin
      pre_cnt_q  <= pre_cnt_d;
      post_cnt_q <= post_cnt_d;
      weight_q   <= weight_d;
      flag_q     <= flag_d;
      ltp_q      <= ltp_d;
      tdiff_q    <= tdiff_d;
    end
  end

  assign weight      = weight_q;
  assign update_flag = flag_q;
  assign ltp         = ltp_q;
  assign time_diff   = tdiff_q;

endmodule

// File: tb/tb_stdp_weight_update.sv
// ---------------------------------------------------------------------------
// tb_stdp_weight_update
//
// Directed bench for stdp_weight_update with default parameters. Each step
// drives one clock of spike inputs, then checks the registered outputs 1 ns
// after the rising edge against hand-computed values.
// ---------------------------------------------------------------------------
module tb_stdp_weight_update;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pre_spike;
  logic       post_spike;
  logic       learn_en;
  logic [7:0] weight;
  logic       update_flag;
  logic       ltp;
  logic [4:0] time_diff;

  int tests = 0;
  int fails = 0;

  stdp_weight_update dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pre_spike   (pre_spike),
    .post_spike  (post_spike),
    .learn_en    (learn_en),
    .weight      (weight),
    .update_flag (update_flag),
    .ltp         (ltp),
    .time_diff   (time_diff)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Check all four outputs after an event (or non-event) step.
  task automatic chk_all(input string tag, input int w, input int f, input int l, input int td);
    chk({tag, "_weight"}, 32'(weight), w);
    chk({tag, "_flag"},   32'(update_flag), f);
    chk({tag, "_ltp"},    32'(ltp), l);
    chk({tag, "_tdiff"},  32'(time_diff), td);
    $display("[TB] %s: weight=%0d flag=%0d ltp=%0d time_diff=%0d",
             tag, weight, update_flag, ltp, time_diff);
  endtask

  // One clock with the given spike inputs; outputs are stable on return.
  task automatic cyc(input logic p, input logic q);
    pre_spike  = p;
    post_spike = q;
    @(posedge clk);
    #1;
    pre_spike  = 1'b0;
    post_spike = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0);
  endtask

  initial begin
    rst_n      = 1'b0;
    pre_spike  = 1'b0;
    post_spike = 1'b0;
    learn_en   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 64, 0, 0, 0);
    rst_n = 1'b1;
    idle(2);

    // LTP: pre, two idle cycles, post -> dt=3, +16
    cyc(1'b1, 1'b0);
    idle(2);
    cyc(1'b0, 1'b1);
    chk_all("ltp_dt3", 80, 1, 1, 3);
    cyc(1'b0, 1'b0);
    chk_all("ltp_pulse_end", 80, 0, 1, 3);

    // Asynchronous reset mid-run, checked before any clock edge
    rst_n = 1'b0;
    #2;
    chk_all("async_reset", 64, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    chk_all("post_after_reset", 64, 0, 0, 0);
    idle(20);

    // LTD: post, five idle cycles, pre -> dt=6, -8
    cyc(1'b0, 1'b1);
    idle(5);
    cyc(1'b1, 1'b0);
    chk_all("ltd_dt6", 56, 1, 0, 6);
    idle(20);

    // Window edge: dt=16 -> +2; dt=17 -> no event, outputs held
    cyc(1'b1, 1'b0);
    idle(15);
    cyc(1'b0, 1'b1);
    chk_all("window_dt16", 58, 1, 1, 16);
    idle(20);
    cyc(1'b1, 1'b0);
    idle(16);
    cyc(1'b0, 1'b1);
    chk_all("window_dt17", 58, 0, 1, 16);
    idle(20);

    // Saturation high: 12 pairs of dt=1 (+16) take 58 to 250
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b1);
      idle(18);
    end
    chk_all("preload", 250, 0, 1, 1);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    chk_all("sat_hi", 255, 1, 1, 1);
    idle(18);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    chk_all("sat_hi_again", 255, 1, 1, 1);
    idle(18);

    // Saturation low: 16 LTD pairs of dt=1 take 255 down to 0 (15 -> 0 last)
    for (int i = 0; i < 16; i++) begin
      if (i != 0) idle(18);
      cyc(1'b0, 1'b1);
      cyc(1'b1, 1'b0);
    end
    chk_all("sat_lo", 0, 1, 0, 1);
    idle(18);
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    chk_all("sat_lo_again", 0, 1, 0, 1);

    // Simultaneous spikes while both traces are valid: no event
    cyc(1'b1, 1'b1);
    chk_all("simul", 0, 0, 0, 1);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    chk_all("post_after_simul", 16, 1, 1, 2);
    idle(18);

    // learn_en=0: outputs held, counters still run
    learn_en = 1'b0;
    cyc(1'b1, 1'b1);
    chk_all("nolearn_simul", 16, 0, 1, 2);
    idle(2);
    cyc(1'b0, 1'b1);
    chk_all("nolearn_post", 16, 0, 1, 2);
    learn_en = 1'b1;
    cyc(1'b1, 1'b0);
    chk_all("learn_resume_ltd", 0, 1, 0, 1);
    idle(20);

    // Nearest pairing: second post after a single pre uses the larger dt
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    chk_all("near_first", 16, 1, 1, 2);
    idle(5);
    cyc(1'b0, 1'b1);
    chk_all("near_second", 24, 1, 1, 8);
    idle(20);

    // Third decay bin: LTD dt=9 -> -4
    cyc(1'b0, 1'b1);
    idle(8);
    cyc(1'b1, 1'b0);
    chk_all("ltd_dt9", 20, 1, 0, 9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
